v810_intc: RTL
==============

// Module: v810_intc
// PURPOSE
//  Parametrised priority interrupt controller for the v810 core: collects NCH device IRQ lines,
//  latches/masks them, and drives the core's INT / INTVn[3:0] pins with the winning level.
//  Successor to the hand-driven INT/INTV stimulus: per-channel enable, edge/level mode and
//  programmable 4-bit level, configured through a small 32-bit register port. NMI is out of scope.
// PARAMETERS
//  NCH   8   number of IRQ channels, 1..32
//  AW    $clog2(4+NCH)   register address width (derived; do not override)
// PORTS
//  CLK     in   1    system clock
//  RESn    in   1    asynchronous active-low reset
//  CE      in   1    clock enable; all state advances only on CLK rising edge with CE=1
//  IRQ     in   NCH  device interrupt requests, active high
//  RD      in   1    register read strobe
//  WR      in   1    register write strobe
//  ADDR    in   AW   register index
//  WDATA   in   32   write data
//  RDATA   out  32   read data, registered
//  INT     out  1    interrupt request to core
//  INTVn   out  4    interrupt level to core, active low (~level)
// BEHAVIOUR
//  Reset (RESn=0, async): ENABLE=0, MODE=0, PENDING=0, all LEVEL=0, irq_prev=0, INT=0, INTVn=4'hF,
//   RDATA=0. A line already high at release counts as a rising edge on the first CE cycle.
//  CE=0: all registers hold; RD/WR ignored.
//  Registers (word index): 0 ENABLE[NCH-1:0]; 1 MODE[NCH-1:0] (0=edge,1=level);
//   2 PENDING (read; write-1-to-clear, edge channels only); 3 STATUS {act[31], ch[12:8], lvl[3:0]};
//   4+k LEVEL[k][3:0]. Unused bits read 0; index >= 4+NCH reads 0, writes dropped.
//  Pending: edge chan: set on IRQ & ~irq_prev; level chan: PENDING[k] = IRQ[k] each CE cycle.
//   Same-cycle edge and W1C on one channel: set wins. Switching MODE does not clear PENDING.
//  Masking: eligible = PENDING & ENABLE; disabling keeps PENDING latched.
//  Priority: highest LEVEL among eligible; tie -> lowest channel index. No eligible -> act=0.
//  Outputs registered from PENDING/ENABLE/LEVEL state: IRQ edge sampled at CE edge n sets PENDING
//   at n; INT/INTVn reflect it after CE edge n+1 (2 CE cycles IRQ->INT). INT=act;
//   INTVn=~lvl when act else 4'hF. Config writes affect INT one CE cycle after the write.
//  No acknowledge cycle: the handler clears edge PENDING via W1C or the device drops its level line;
//   INT deasserts one CE cycle after the clear lands.
//  RDATA: captured on CE edge with RD=1 (1-cycle latency), holds otherwise. RD&WR same index:
//   RDATA returns pre-write value.
//  Level 0 is legal; CPU-side masking against PSW.I is the core's job, not this block's.
// CONFIGURATION
//  V810_INTC_SYNC_EN defined: 2-flop synchroniser on each IRQ bit before edge detect/level sample;
//   IRQ->INT latency becomes 4 CE cycles; sync flops reset to 0.
//  Not defined: IRQ used directly (must be synchronous to CLK); latency 2 CE cycles.
// STRUCTURE
//  Package v810_intc_pkg: register index localparams (REG_ENABLE..REG_LEVEL0), typedef logic [3:0]
//   int_level_t, typedef struct packed {act, ch, lvl} int_status_t.
//  Sub-module v810_intc_prio: combinational NCH-way max-level/lowest-index resolver -> int_status_t.
// TESTING
//  Reset: RESn low with IRQ toggling -> INT=0, INTVn=4'hF, all registers read 0.
//  Edge: LEVEL[3]=8, ENABLE=8'h08, pulse IRQ[3] 1 cycle -> INT=1, INTVn=4'h7 2 CE cycles later;
//   holds after IRQ drop; W1C PENDING=8'h08 -> INT=0 next CE cycle.
//  Priority: LEVEL[1]=5, LEVEL[6]=12, LEVEL[2]=12, all enabled, IRQ 1,2,6 -> STATUS ch=2 lvl=12;
//   clear ch2 -> ch=6 lvl=12; clear ch6 -> ch=1 lvl=5.
//  Level mode: MODE[0]=1, LEVEL[0]=15, IRQ[0] held high -> INTVn=4'h0; W1C ignored; drop IRQ -> INT=0.
//  Mask/race: pending ch4 with ENABLE=0 -> INT=0; enable -> INT=1 next cycle; W1C same cycle as
//   new edge -> PENDING[4] stays 1. CE held low 10 cycles -> no state change.
//  Sync: with V810_INTC_SYNC_EN, edge test latency measured as 4 CE cycles; async RESn mid-pending
//   clears INT immediately.
//  Core integration: hook to v810 INT/INTVn, INT level 8 program -> PSW/EIPC/ECR.EICC=16'hfe80 as
//   the direct-stimulus INT8 case.

Source files
------------

// File: rtl/v810_intc_pkg.sv
// ----------------------------------------------------------------------------
// v810_intc_pkg
// Shared definitions for the v810 priority interrupt controller.
//   REG_*          : word indices of the register port
//   int_level_t    : 4-bit interrupt level as presented to the core
//   int_status_t   : resolved winner {act, ch, lvl}
// ----------------------------------------------------------------------------
package v810_intc_pkg;

    localparam int REG_ENABLE  = 0;
    localparam int REG_MODE    = 1;
    localparam int REG_PENDING = 2;
    localparam int REG_STATUS  = 3;
    localparam int REG_LEVEL0  = 4;

    typedef logic [3:0] int_level_t;

    typedef struct packed {
        logic       act;
        logic [4:0] ch;
        int_level_t lvl;
    } int_status_t;

endpackage

// File: rtl/v810_intc_prio.sv
// ----------------------------------------------------------------------------
// v810_intc_prio
// Combinational NCH-way resolver: picks the eligible channel with the highest
// level; ties go to the lowest channel index. No eligible channel -> act=0.
// Ports:
//   i_eligible [NCH]   : PENDING & ENABLE
//   i_levels   [4*NCH] : channel k level in bits [4k+3:4k]
//   o_status           : winner {act, ch, lvl}
// ----------------------------------------------------------------------------
module v810_intc_prio
    import v810_intc_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]   i_eligible,
    input  logic [4*NCH-1:0] i_levels,
    output int_status_t      o_status
);

    int_status_t w_best;

    // Scan from the top index down and accept equal levels, so the lowest
    // index among equal-level candidates is the one left standing.
    always_comb begin
        w_best = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (i_eligible[k] && (!w_best.act || i_levels[4*k +: 4] >= w_best.lvl)) begin
                w_best.act = 1'b1;
                w_best.ch  = 5'(k);
                w_best.lvl = i_levels[4*k +: 4];
            end
        end
    end

    assign o_status = w_best;

endmodule

// File: rtl/v810_intc.sv
// ----------------------------------------------------------------------------
// v810_intc
// Priority interrupt controller for the v810 core. Latches NCH device IRQ
// lines (edge or level per channel), masks them with ENABLE, and drives the
// core's INT / INTVn pins with the highest-level eligible request.
// Ports:
//   CLK, RESn (async active-low), CE (clock enable)
//   IRQ[NCH]           : device requests, active high
//   RD, WR, ADDR, WDATA: register port (RDATA registered, 1-cycle latency)
//   INT, INTVn[3:0]    : core interrupt request and active-low level
// Build option:
//   V810_INTC_SYNC_EN  : 2-flop synchroniser on every IRQ bit
// ----------------------------------------------------------------------------
module v810_intc
    import v810_intc_pkg::*;
#(
    parameter int NCH = 8,
    parameter int AW  = $clog2(4 + NCH)
) (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    input  logic [NCH-1:0] IRQ,
    input  logic          RD,
    input  logic          WR,
    input  logic [AW-1:0] ADDR,
    input  logic [31:0]   WDATA,
    output logic [31:0]   RDATA,
    output logic          INT,
    output logic [3:0]    INTVn
);

    logic [NCH-1:0]   r_enable;
    logic [NCH-1:0]   r_mode;
    logic [NCH-1:0]   r_pending;
    logic [NCH-1:0]   r_irqPrev;
    logic [4*NCH-1:0] r_level;
    logic             r_int;
    logic [3:0]       r_intvn;
    logic [31:0]      r_rdata;

    logic [NCH-1:0]   w_irqS;
    logic [NCH-1:0]   w_clear;
    logic [NCH-1:0]   w_nextPending;
    logic [31:0]      w_readData;
    int_status_t      w_status;
    logic             w_unusedBits;

    // WDATA is wider than any single register; upper bits are intentionally ignored.
    assign w_unusedBits = ^WDATA;

`ifdef V810_INTC_SYNC_EN
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;

    // Two-flop synchroniser for IRQ lines that are asynchronous to CLK.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else if (CE) begin
            r_sync1 <= IRQ;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irqS = r_sync2;
`else
    assign w_irqS = IRQ;
`endif

    // W1C only touches edge channels; a fresh edge in the same cycle wins
    // because the set term is ORed in after the clear.
    always_comb begin
        w_clear = '0;
        if (WR && int'(ADDR) == REG_PENDING) begin
            w_clear = WDATA[NCH-1:0] & ~r_mode;
        end
        w_nextPending = (r_mode & w_irqS)
                      | (~r_mode & ((r_pending & ~w_clear) | (w_irqS & ~r_irqPrev)));
    end

    v810_intc_prio #(.NCH(NCH)) u_prio (
        .i_eligible (r_pending & r_enable),
        .i_levels   (r_level),
        .o_status   (w_status)
    );

    // Read mux sees the state before any same-cycle write lands.
    always_comb begin
        w_readData = '0;
        if (int'(ADDR) == REG_ENABLE) begin
            w_readData[NCH-1:0] = r_enable;
        end else if (int'(ADDR) == REG_MODE) begin
            w_readData[NCH-1:0] = r_mode;
        end else if (int'(ADDR) == REG_PENDING) begin
            w_readData[NCH-1:0] = r_pending;
        end else if (int'(ADDR) == REG_STATUS) begin
            w_readData = {w_status.act, 18'b0, w_status.ch, 4'b0, w_status.lvl};
        end else if (int'(ADDR) >= REG_LEVEL0 && int'(ADDR) < REG_LEVEL0 + NCH) begin
            w_readData[3:0] = r_level[4*(int'(ADDR) - REG_LEVEL0) +: 4];
        end
    end

    // Core state: pending capture, config writes, outputs registered from the
    // resolver so INT trails PENDING/ENABLE/LEVEL by one CE cycle.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_pending <= '0;
            r_irqPrev <= '0;
            r_level   <= '0;
            r_int     <= 1'b0;
            r_intvn   <= 4'hF;
            r_rdata   <= '0;
        end else if (CE) begin
            r_irqPrev <= w_irqS;
            r_pending <= w_nextPending;
            if (WR && int'(ADDR) == REG_ENABLE) begin
                r_enable <= WDATA[NCH-1:0];
            end
            if (WR && int'(ADDR) == REG_MODE) begin
                r_mode <= WDATA[NCH-1:0];
            end
            for (int k = 0; k < NCH; k++) begin
                if (WR && int'(ADDR) == REG_LEVEL0 + k) begin
                    r_level[4*k +: 4] <= WDATA[3:0];
                end
            end
            r_int   <= w_status.act;
            r_intvn <= w_status.act ? ~w_status.lvl : 4'hF;
            if (RD) begin
                r_rdata <= w_readData;
            end
        end
    end

    assign RDATA = r_rdata;
    assign INT   = r_int;
    assign INTVn = r_intvn;

endmodule
